// File: rtl/axi_fsrc_pkg.sv
// Shared types and constants for the TX fractional sample-rate converter sequencer.
// Holds the sequencer state encoding and default widths used by the sequencer files.
package axi_fsrc_pkg;

    localparam int FSRC_STATE_W         = 3;
    localparam int FSRC_CNT_W_DEFAULT   = 32;
    localparam int FSRC_ACCUM_W_DEFAULT = 64;

    typedef enum logic [FSRC_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_SETUP = 3'd3,
        ST_RUN   = 3'd4,
        ST_STOP  = 3'd5
    } fsrc_seq_state_t;

    // The datapath is enabled from accumulator load through the stop pulse.
    function automatic logic fsrc_state_enabled(input fsrc_seq_state_t s);
        logic en;
        case (s)
            ST_SETUP, ST_RUN, ST_STOP: en = 1'b1;
            default:                   en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/axi_fsrc_rate_shadow.sv
// Double-buffered rate increment: writes land in a shadow register and are
// applied to the active increment only when the sequencer allows it.
module axi_fsrc_rate_shadow #(
    parameter int ACCUM_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rate_wr,
    input  logic [ACCUM_WIDTH-1:0] rate_val,
    input  logic                   in_run,
    input  logic                   beat,
    output logic [ACCUM_WIDTH-1:0] accum_add_val,
    output logic                   rate_pending
);

    logic [ACCUM_WIDTH-1:0] shadow_r;
    logic [ACCUM_WIDTH-1:0] active_r;
    logic                   pending_r;
    logic                   apply_s;

    // Apply enable: while running, only on an output beat; otherwise any cycle.
    always_comb begin
        apply_s = 1'b0;
        if (in_run) begin
            apply_s = pending_r & beat;
        end else begin
            apply_s = pending_r;
        end
    end

    // Shadow/active registers; a write colliding with an apply keeps pending set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_r  <= '0;
            active_r  <= '0;
            pending_r <= 1'b0;
        end else begin
            if (apply_s) begin
                active_r <= shadow_r;
            end
            if (rate_wr) begin
                shadow_r  <= rate_val;
                pending_r <= 1'b1;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign accum_add_val = active_r;
    assign rate_pending  = pending_r;

endmodule

// File: rtl/axi_fsrc_tx_sequencer.sv
// TX fractional SRC sequencer: arm, optional trigger, start delay, accumulator
// load, start, beat-counted run and stop, plus the double-buffered rate increment.
module axi_fsrc_tx_sequencer
    import axi_fsrc_pkg::*;
#(
    parameter int ACCUM_WIDTH = FSRC_ACCUM_W_DEFAULT,
    parameter int CNT_WIDTH   = FSRC_CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cfg_arm,
    input  logic                    cfg_abort,
    input  logic                    cfg_ext_trig_en,
    input  logic                    ext_trig,
    input  logic [CNT_WIDTH-1:0]    cfg_start_delay,
    input  logic [CNT_WIDTH-1:0]    cfg_run_length,
    input  logic [ACCUM_WIDTH-1:0]  cfg_rate_val,
    input  logic                    cfg_rate_wr,
    input  logic                    dp_out_valid,
    input  logic                    dp_out_ready,
    output logic                    fsrc_enable,
    output logic                    fsrc_accum_set,
    output logic                    fsrc_start,
    output logic                    fsrc_stop,
    output logic [ACCUM_WIDTH-1:0]  accum_add_val,
    output logic                    rate_pending,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_WIDTH-1:0]    beat_count,
    output logic [FSRC_STATE_W-1:0] state
);

    fsrc_seq_state_t        state_r;
    fsrc_seq_state_t        state_nxt_s;
    logic [CNT_WIDTH-1:0]   delay_snap_r;
    logic [CNT_WIDTH-1:0]   run_len_snap_r;
    logic [CNT_WIDTH-1:0]   delay_cnt_r;
    logic [CNT_WIDTH-1:0]   beat_count_r;
    logic                   done_r;
    logic                   enable_r;
    logic                   accum_set_r;
    logic                   start_r;
    logic                   stop_r;
    logic                   busy_r;
    logic                   beat_s;
    logic                   arm_accept_s;
    logic                   trig_ok_s;
    logic                   run_last_s;

    // Qualifiers shared by the next-state logic and the counters.
    always_comb begin
        beat_s       = dp_out_valid & dp_out_ready;
        arm_accept_s = (state_r == ST_IDLE) & cfg_arm;
        trig_ok_s    = ~cfg_ext_trig_en | ext_trig;
        run_last_s   = (run_len_snap_r != '0) & beat_s &
                       (beat_count_r == (run_len_snap_r - CNT_WIDTH'(1)));
    end

    // Next-state logic; abort outranks run-length completion and progression.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_arm) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (cfg_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (trig_ok_s) begin
                    state_nxt_s = ST_DELAY;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_DELAY: begin
                if (cfg_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (delay_cnt_r == '0) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_DELAY;
                end
            end
            ST_SETUP: begin
                if (cfg_abort) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_abort || run_last_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and pulse registers; pulses are decoded from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            enable_r    <= 1'b0;
            accum_set_r <= 1'b0;
            start_r     <= 1'b0;
            stop_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            enable_r    <= fsrc_state_enabled(state_nxt_s);
            accum_set_r <= (state_nxt_s == ST_SETUP);
            start_r     <= (state_nxt_s == ST_RUN) && (state_r == ST_SETUP);
            stop_r      <= (state_nxt_s == ST_STOP);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Config snapshots, delay countdown, beat counter and sticky done flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay_snap_r   <= '0;
            run_len_snap_r <= '0;
            delay_cnt_r    <= '0;
            beat_count_r   <= '0;
            done_r         <= 1'b0;
        end else begin
            if (arm_accept_s) begin
                delay_snap_r   <= cfg_start_delay;
                run_len_snap_r <= cfg_run_length;
            end
            case (state_r)
                ST_ARMED: delay_cnt_r <= delay_snap_r;
                ST_DELAY: begin
                    if (delay_cnt_r != '0) begin
                        delay_cnt_r <= delay_cnt_r - CNT_WIDTH'(1);
                    end
                end
                default: delay_cnt_r <= delay_cnt_r;
            endcase
            if (arm_accept_s || (state_r == ST_SETUP)) begin
                beat_count_r <= '0;
            end else if ((state_r == ST_RUN) && beat_s && (beat_count_r != '1)) begin
                beat_count_r <= beat_count_r + CNT_WIDTH'(1);
            end
            if (arm_accept_s) begin
                done_r <= 1'b0;
            end else if (state_r == ST_STOP) begin
                done_r <= 1'b1;
            end
        end
    end

    axi_fsrc_rate_shadow #(
        .ACCUM_WIDTH (ACCUM_WIDTH)
    ) u_rate_shadow (
        .clk           (clk),
        .resetn        (resetn),
        .rate_wr       (cfg_rate_wr),
        .rate_val      (cfg_rate_val),
        .in_run        (state_r == ST_RUN),
        .beat          (beat_s),
        .accum_add_val (accum_add_val),
        .rate_pending  (rate_pending)
    );

    assign fsrc_enable    = enable_r;
    assign fsrc_accum_set = accum_set_r;
    assign fsrc_start     = start_r;
    assign fsrc_stop      = stop_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign beat_count     = beat_count_r;
    assign state          = state_r;

endmodule

// File: tb/tb_axi_fsrc_tx_sequencer.sv
// Self-checking bench for axi_fsrc_tx_sequencer: expected timelines are derived
// from phase lengths and a pre-drawn random beat pattern.
module tb_axi_fsrc_tx_sequencer;

    localparam int AW   = 64;
    localparam int CW   = 32;
    localparam int MAXC = 256;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_arm = 1'b0, cfg_abort = 1'b0, cfg_ext_trig_en = 1'b0, ext_trig = 1'b0;
    logic [CW-1:0] cfg_start_delay = '0, cfg_run_length = '0;
    logic [AW-1:0] cfg_rate_val = '0;
    logic          cfg_rate_wr = 1'b0, dp_out_valid = 1'b0, dp_out_ready = 1'b0;
    logic          fsrc_enable, fsrc_accum_set, fsrc_start, fsrc_stop, rate_pending, busy, done;
    logic [AW-1:0] accum_add_val;
    logic [CW-1:0] beat_count;
    logic [2:0]    state;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] exp_accum = '0;
    bit            bt [MAXC];

    wire [AW+CW+9:0] all_outs = {accum_add_val, beat_count, state, fsrc_enable, fsrc_accum_set,
                                 fsrc_start, fsrc_stop, rate_pending, busy, done};

    axi_fsrc_tx_sequencer #(.ACCUM_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_ext_trig_en(cfg_ext_trig_en), .ext_trig(ext_trig),
        .cfg_start_delay(cfg_start_delay), .cfg_run_length(cfg_run_length),
        .cfg_rate_val(cfg_rate_val), .cfg_rate_wr(cfg_rate_wr),
        .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
        .fsrc_enable(fsrc_enable), .fsrc_accum_set(fsrc_accum_set), .fsrc_start(fsrc_start),
        .fsrc_stop(fsrc_stop), .accum_add_val(accum_add_val), .rate_pending(rate_pending),
        .busy(busy), .done(done), .beat_count(beat_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cfg_arm = 1'b0; cfg_abort = 1'b0; ext_trig = 1'b0; cfg_rate_wr = 1'b0;
        dp_out_valid = 1'b0; dp_out_ready = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int n = 0; n < 12 && state !== S_RUN; n++) step;
        checks++;
        if (state !== S_RUN) begin
            errors++;
            $display("FAIL %s wait_run: state=%0d want %0d", tag, state, S_RUN);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle_inputs();
        repeat (3) step;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h want 0", all_outs);
        end
        resetn = 1'b1;
        step;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h want 0", all_outs);
        end
    endtask

    // d: delay, r: run length, te/ta: trigger enable and ARMED-cycle index of the
    // trigger, ab: cycle index of an abort pulse (-1 none), pct: beat probability.
    task automatic run_sequence(input int d, input int r, input bit te, input int ta,
                                input int ab, input int pct, input string tag);
        int a_len, s_i, stop_i, idle_i, nat, cnt, ebc, lim;
        logic [2:0] es;
        logic [8:0] ev, ov;
        bit ed;
        a_len = te ? ta + 1 : 1;
        s_i   = a_len + d + 1;
        for (int i = 0; i < MAXC; i++) bt[i] = ($urandom_range(99) < pct);
        if (ab >= 0 && ab < s_i) begin
            stop_i = -1;
            idle_i = ab + 1;
        end else begin
            nat = MAXC + 10;
            cnt = 0;
            if (r != 0) begin
                for (int j = s_i + 1; j < MAXC; j++) begin
                    if (bt[j] && nat > MAXC) begin
                        cnt++;
                        if (cnt == r) nat = j + 1;
                    end
                end
            end
            stop_i = (ab >= 0 && ab + 1 < nat) ? ab + 1 : nat;
            idle_i = stop_i + 1;
        end
        cfg_start_delay = CW'(d);
        cfg_run_length  = CW'(r);
        cfg_ext_trig_en = te;
        cfg_arm = 1'b1;
        step;
        cfg_arm = 1'b0;
        cfg_start_delay = $urandom;
        cfg_run_length  = $urandom;
        for (int i = 0; i <= idle_i + 1 && i < MAXC; i++) begin
            if (bt[i]) begin
                dp_out_valid = 1'b1; dp_out_ready = 1'b1;
            end else begin
                dp_out_valid = 1'($urandom_range(1));
                dp_out_ready = dp_out_valid ? 1'b0 : 1'($urandom_range(1));
            end
            cfg_abort = (i == ab);
            cfg_arm   = (i == s_i) && (s_i < idle_i);
            ext_trig  = te ? (i >= ta) : 1'($urandom_range(1));
            if (i >= idle_i)                    es = S_IDLE;
            else if (stop_i >= 0 && i == stop_i) es = S_STOP;
            else if (i < a_len)                 es = S_ARMED;
            else if (i < s_i)                   es = S_DELAY;
            else if (i == s_i)                  es = S_SETUP;
            else                                es = S_RUN;
            ed  = (stop_i >= 0) && (i >= idle_i);
            ebc = 0;
            if (stop_i >= 0) begin
                lim = (i < stop_i) ? i : stop_i;
                for (int j = s_i + 1; j < lim; j++) ebc += int'(bt[j]);
            end
            ev = {es, (es == S_SETUP || es == S_RUN || es == S_STOP), es == S_SETUP,
                  (es == S_RUN && i == s_i + 1), es == S_STOP, es != S_IDLE, ed};
            ov = {state, fsrc_enable, fsrc_accum_set, fsrc_start, fsrc_stop, busy, done};
            checks++;
            if (ov !== ev) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: {state,en,set,start,stop,busy,done} got %b want %b",
                         tag, i, ov, ev);
            end
            checks++;
            if (beat_count !== CW'(ebc)) begin
                errors++;
                $display("FAIL %s beat_count cycle %0d: got %0d want %0d", tag, i, beat_count, ebc);
            end
            step;
        end
        idle_inputs();
        cfg_abort = 1'b1;
        repeat (3) step;
        cfg_abort = 1'b0;
    endtask

    task automatic test_immediate_start;
        run_sequence(3, 5, 1'b0, 0, -1, 100, "immediate");
    endtask

    task automatic test_ext_trigger;
        run_sequence(0, 3, 1'b1, 19, -1, 70, "ext_trig");
    endtask

    task automatic test_abort;
        run_sequence(6, 4, 1'b0, 0, 3, 60, "abort_delay");
        run_sequence(1, 0, 1'b0, 0, 10, 50, "abort_run");
        run_sequence(2, 4, 1'b1, 10, 4, 60, "abort_armed");
        run_sequence(0, 4, 1'b0, 0, 2, 60, "abort_setup");
    endtask

    task automatic test_random_sequences;
        int d, r, ta, ab, pct;
        bit te;
        for (int it = 0; it < 12; it++) begin
            d   = $urandom_range(6);
            r   = $urandom_range(8, 1);
            te  = 1'($urandom_range(1));
            ta  = $urandom_range(8);
            ab  = ($urandom_range(1) == 1) ? $urandom_range(30) : -1;
            if (ab >= 0 && $urandom_range(3) == 0) r = 0;
            pct = 40 + $urandom_range(60);
            run_sequence(d, r, te, ta, ab, pct, "random");
        end
    endtask

    // Outside RUN a write lands two cycles later and pending is high for one cycle.
    task automatic test_rate_idle_random;
        logic [AW-1:0] vals [64];
        bit            wrs  [64];
        logic [AW-1:0] acc;
        bit            ep;
        acc = exp_accum;
        for (int k = 0; k < 42; k++) begin
            if (k >= 2 && wrs[k-2]) acc = vals[k-2];
            ep = (k >= 1) ? wrs[k-1] : 1'b0;
            checks++;
            if (accum_add_val !== acc) begin
                errors++;
                $display("FAIL rate_idle accum cycle %0d: got %h want %h", k, accum_add_val, acc);
            end
            checks++;
            if (rate_pending !== ep) begin
                errors++;
                $display("FAIL rate_idle pending cycle %0d: got %b want %b", k, rate_pending, ep);
            end
            wrs[k]  = (k < 40) && ($urandom_range(99) < 40);
            vals[k] = {$urandom, $urandom};
            cfg_rate_wr  = wrs[k];
            cfg_rate_val = vals[k];
            step;
        end
        cfg_rate_wr = 1'b0;
        exp_accum = acc;
    endtask

    task automatic test_rate_collision;
        cfg_rate_wr = 1'b1; cfg_rate_val = 64'hA;
        step;
        checks++;
        if (rate_pending !== 1'b1 || accum_add_val !== exp_accum) begin
            errors++;
            $display("FAIL collision_c1: pending=%b accum=%h want 1 %h", rate_pending, accum_add_val, exp_accum);
        end
        cfg_rate_val = 64'hB;
        step;
        cfg_rate_wr = 1'b0;
        checks++;
        if (rate_pending !== 1'b1 || accum_add_val !== 64'hA) begin
            errors++;
            $display("FAIL collision_c2: pending=%b accum=%h want 1 a", rate_pending, accum_add_val);
        end
        step;
        checks++;
        if (rate_pending !== 1'b0 || accum_add_val !== 64'hB) begin
            errors++;
            $display("FAIL collision_c3: pending=%b accum=%h want 0 b", rate_pending, accum_add_val);
        end
        exp_accum = 64'hB;
    endtask

    task automatic test_rate_in_run;
        cfg_start_delay = 32'd0; cfg_run_length = 32'd0; cfg_ext_trig_en = 1'b0;
        dp_out_valid = 1'b1; dp_out_ready = 1'b0;
        cfg_arm = 1'b1;
        step;
        cfg_arm = 1'b0;
        wait_run("rate_run");
        cfg_rate_wr = 1'b1; cfg_rate_val = 64'h10;
        step;
        cfg_rate_wr = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) dp_out_ready = 1'b1;
            checks++;
            if (accum_add_val !== exp_accum || rate_pending !== 1'b1) begin
                errors++;
                $display("FAIL rate_run_hold cycle %0d: accum=%h pending=%b want %h 1",
                         k, accum_add_val, rate_pending, exp_accum);
            end
            step;
        end
        dp_out_ready = 1'b0;
        checks++;
        if (accum_add_val !== 64'h10 || rate_pending !== 1'b0) begin
            errors++;
            $display("FAIL rate_run_apply: accum=%h pending=%b want 10 0", accum_add_val, rate_pending);
        end
        exp_accum = 64'h10;
        cfg_abort = 1'b1;
        step;
        cfg_abort = 1'b0;
        checks++;
        if (state !== S_STOP || fsrc_stop !== 1'b1) begin
            errors++;
            $display("FAIL rate_run_stop: state=%0d stop=%b want 5 1", state, fsrc_stop);
        end
        step;
        checks++;
        if (state !== S_IDLE || done !== 1'b1 || beat_count !== 32'd1 || fsrc_stop !== 1'b0) begin
            errors++;
            $display("FAIL rate_run_end: state=%0d done=%b beats=%0d stop=%b want 0 1 1 0",
                     state, done, beat_count, fsrc_stop);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset;
        cfg_start_delay = 32'd1; cfg_run_length = 32'd0; cfg_ext_trig_en = 1'b0;
        dp_out_valid = 1'b1; dp_out_ready = 1'b1;
        cfg_arm = 1'b1;
        step;
        cfg_arm = 1'b0;
        wait_run("async_reset");
        repeat (3) step;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate: outputs=%h want 0", all_outs);
        end
        step;
        idle_inputs();
        #2;
        resetn = 1'b1;
        exp_accum = '0;
        for (int k = 0; k < 5; k++) begin
            step;
            checks++;
            if (all_outs !== '0) begin
                errors++;
                $display("FAIL async_reset_release cycle %0d: outputs=%h want 0", k, all_outs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_immediate_start();
        test_ext_trigger();
        test_abort();
        test_random_sequences();
        test_rate_idle_random();
        test_rate_collision();
        test_rate_in_run();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
